// File: rtl/adc_lvds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_lvds_pkg
//  Description : Constants shared across the ADC LVDS link: the 14:1 DDR
//                serializer, the 1:14 DDR receiver and the alignment
//                controller. Every block reads its word width and its
//                training/frame patterns from here so that they stay in step.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_lvds_pkg;

    // ADC sample width in bits
    localparam int ADC_WIDTH = 14;

    // Training word. The receiver's bitslip search looks for this pattern.
    localparam logic [13:0] TRAIN_WORD_DEF = 14'h3F80;

    // Frame-clock (FCO) pattern. It is sent alongside every word and is
    // never rotated.
    localparam logic [13:0] FRAME_WORD_DEF = 14'h3F80;

    typedef logic [ADC_WIDTH-1:0] adc_word_t;

endpackage : adc_lvds_pkg
`default_nettype wire

// File: rtl/serdes_14x1_ddr_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_14x1_ddr_tx_if
//  Description : Parallel-word and serial-pair bundle of the 14:1 DDR
//                serializer.
//                  data_in/data_valid/data_ready : word handshake
//                  train_en                      : send training word
//                  slip                          : rotate data by one more bit
//                  dout_r/dout_f                 : data bit pair for the ODDR
//                  frame_r/frame_f               : frame-clock bit pair
//                  word_start                    : first pair of a word
//                  underrun                      : a slot had no valid word
//                The serializer connects to the slave modport. The word
//                source connects to the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serdes_14x1_ddr_tx_if
    import adc_lvds_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH
) ();

    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             train_en;
    logic             slip;
    logic             dout_r;
    logic             dout_f;
    logic             frame_r;
    logic             frame_f;
    logic             word_start;
    logic             underrun;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        output train_en,
        output slip,
        input  dout_r,
        input  dout_f,
        input  frame_r,
        input  frame_f,
        input  word_start,
        input  underrun
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        input  train_en,
        input  slip,
        output dout_r,
        output dout_f,
        output frame_r,
        output frame_f,
        output word_start,
        output underrun
    );

endinterface : serdes_14x1_ddr_tx_if
`default_nettype wire

// File: rtl/serdes_word_rotl.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_word_rotl
//  Description : Combinational rotate-left of a WIDTH-bit word by i_off bits.
//                i_off must be within 0..WIDTH-1.
//  Ports       : i_word - word to rotate
//                i_off  - rotate-left amount
//                o_word - rotated word
//  Revision    : 1.0 - initial release
// ============================================================================
module serdes_word_rotl #(
    parameter int WIDTH = 14,
    parameter int OFF_W = 4
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [OFF_W-1:0] i_off,
    output logic [WIDTH-1:0] o_word
);

    // With i_off == 0 the right shift is by WIDTH. That yields zero, so the
    // word passes through unchanged.
    assign o_word = (i_word << i_off) | (i_word >> (WIDTH - int'(i_off)));

endmodule : serdes_word_rotl
`default_nettype wire

// File: rtl/serdes_14x1_ddr_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_14x1_ddr_tx
//  Description : 14:1 DDR serializer. This is the transmit side of the ADC
//                LVDS link.
//                Each clk cycle it emits one rising/falling bit pair for a
//                downstream ODDR, plus a matching frame-clock pair. Bits go
//                out MSB first. One word takes WIDTH/2 cycles, and the stream
//                has no gaps between words.
//                A training mode sends TRAIN_WORD. The slip input rotates
//                data words left by one extra bit, which lets the receiver's
//                bitslip logic be exercised.
//  Ports       : clk    - bit-pair clock, sole clock
//                rst_n  - synchronous reset, active low
//                bus    - serdes_14x1_ddr_tx_if.slave (handshake + serial pairs)
//  Revision    : 1.0 - initial release
// ============================================================================
module serdes_14x1_ddr_tx
    import adc_lvds_pkg::*;
#(
    parameter int               WIDTH      = ADC_WIDTH,
    parameter logic [WIDTH-1:0] TRAIN_WORD = TRAIN_WORD_DEF[WIDTH-1:0],
    parameter logic [WIDTH-1:0] FRAME_WORD = FRAME_WORD_DEF[WIDTH-1:0]
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serdes_14x1_ddr_tx_if.slave  bus
);

    localparam int                 c_PAIRS   = WIDTH / 2;
    localparam int                 c_CNT_W   = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;
    localparam int                 c_OFF_W   = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_PAIRS - 1);
    localparam logic [c_OFF_W-1:0] c_OFF_MAX = c_OFF_W'(WIDTH - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_OFF_W-1:0] r_off;
    logic               r_slip_pend;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_frame;
    logic               r_word_start;
    logic               r_underrun;

    logic               w_load;
    logic               w_slip_now;
    logic [c_OFF_W-1:0] w_off_nxt;
    logic [WIDTH-1:0]   w_rot;
    logic [WIDTH-1:0]   w_word;

    // The last pair of a word is the slot in which the next word is loaded.
    // The counter resets to this value, so loading starts immediately after
    // reset is released.
    assign w_load = (r_cnt == c_LAST);

    // A slip that arrives in the load cycle itself is applied at that load.
    assign w_slip_now = r_slip_pend | bus.slip;

    always_comb begin
        w_off_nxt = r_off;
        if (w_slip_now) begin
            w_off_nxt = (r_off == c_OFF_MAX) ? '0 : r_off + 1'b1;
        end
    end

    serdes_word_rotl #(
        .WIDTH (WIDTH),
        .OFF_W (c_OFF_W)
    ) u_rotl (
        .i_word (bus.data_in),
        .i_off  (w_off_nxt),
        .o_word (w_rot)
    );

    // Select the word for this slot. Training words are never rotated. When
    // no word is valid, the slot is filled with zeros.
    always_comb begin
        w_word = '0;
        if (bus.train_en) begin
            w_word = TRAIN_WORD;
        end else if (bus.data_valid) begin
            w_word = w_rot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= c_LAST;
            r_off        <= '0;
            r_slip_pend  <= 1'b0;
            r_shift      <= '0;
            r_frame      <= '0;
            r_word_start <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_word_start <= w_load;
            r_underrun   <= w_load & ~bus.train_en & ~bus.data_valid;
            if (w_load) begin
                r_cnt       <= '0;
                r_off       <= w_off_nxt;
                r_slip_pend <= 1'b0;
                r_shift     <= w_word;
                r_frame     <= FRAME_WORD;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= {r_shift[WIDTH-3:0], 2'b00};
                r_frame <= {r_frame[WIDTH-3:0], 2'b00};
                if (bus.slip) begin
                    r_slip_pend <= 1'b1;
                end
            end
        end
    end

    // The pair outputs are taken directly from the top two shift-register
    // bits. The earlier (more significant) bit goes to the rising edge.
    assign bus.dout_r     = r_shift[WIDTH-1];
    assign bus.dout_f     = r_shift[WIDTH-2];
    assign bus.frame_r    = r_frame[WIDTH-1];
    assign bus.frame_f    = r_frame[WIDTH-2];
    assign bus.word_start = r_word_start;
    assign bus.underrun   = r_underrun;
    assign bus.data_ready = rst_n & w_load & ~bus.train_en;

endmodule : serdes_14x1_ddr_tx
`default_nettype wire

// File: tb/tb_serdes_14x1_ddr_tx.sv
`timescale 1ns/1ps
module tb_serdes_14x1_ddr_tx;
    import adc_lvds_pkg::*;

    localparam int W = 14;
    localparam int P = W / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serdes_14x1_ddr_tx_if #(.WIDTH(W)) bus ();

    serdes_14x1_ddr_tx #(
        .WIDTH      (W),
        .TRAIN_WORD (14'h3F80),
        .FRAME_WORD (14'h3F80)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] obs;
    assign obs = {bus.dout_r, bus.dout_f, bus.frame_r, bus.frame_f, bus.word_start, bus.underrun};

    // Reference model. At every load slot it picks a whole word from the
    // selection rules, then plays that word out two bits at a time.
    int         m_phase, m_off, m_word, m_frame, m_idx;
    bit         m_pend, m_ws, m_ur;
    logic [5:0] m_exp;

    function automatic int rotl(input int x, input int n);
        return ((x << n) | (x >> (W - n))) & ((1 << W) - 1);
    endfunction

    function automatic logic exp_ready();
        return rst_n && (m_phase == 0) && !bus.train_en;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_off = 0; m_pend = 0;
            m_word = 0; m_frame = 0; m_idx = W - 1;
            m_exp = '0;
        end else begin
            m_ws = 0; m_ur = 0;
            if (m_phase == 0) begin
                if (m_pend || bus.slip) m_off = (m_off + 1) % W;
                m_pend = 0;
                if (bus.train_en)        m_word = 32'h3F80;
                else if (bus.data_valid) m_word = rotl(int'(bus.data_in), m_off);
                else begin m_word = 0; m_ur = 1; end
                m_frame = 32'h3F80;
                m_idx = W - 1;
                m_ws = 1;
            end else if (bus.slip) begin
                m_pend = 1;
            end
            m_exp = {m_word[m_idx], m_word[m_idx-1], m_frame[m_idx], m_frame[m_idx-1], m_ws, m_ur};
            m_idx -= 2;
            m_phase = (m_phase + 1) % P;
        end
    end

    task automatic drive(input logic dv, input logic [13:0] d, input logic tr, input logic sl);
        bus.data_valid = dv;
        bus.data_in    = d;
        bus.train_en   = tr;
        bus.slip       = sl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 14'h0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if ({obs, bus.data_ready} !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_outputs t=%0t got %b want 0000000", $time, {obs, bus.data_ready});
            end
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_ready t=%0t got %b want 1", $time, bus.data_ready);
        end
    endtask

    // Starts in the first load slot after reset.
    task automatic test_word();
        logic [1:0] dp [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        logic [1:0] fp [7] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [5:0] want;
        drive(1'b1, 14'h2A5C, 1'b0, 1'b0);
        for (int i = 0; i < P; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 14'($urandom), 1'b0, 1'b0);
            want = {dp[i], fp[i], (i == 0), 1'b0};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL word_2a5c pair=%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_underrun();
        logic [1:0] fp [7] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [5:0] want;
        for (int i = 0; i < P; i++) begin
            drive(1'b0, 14'($urandom), 1'b0, 1'b0);
            #1;
            vectors++;
            if (bus.data_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL underrun_ready t=%0t got %b want %b", $time, bus.data_ready, exp_ready());
            end
            @(posedge clk); #1;
            want = {2'b00, fp[i], (i == 0), (i == 0)};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL underrun_pair pair=%0d got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] cap = '0;
        for (int c = 0; c < 2 * P; c++) begin
            if (c == 0)      drive(1'b1, 14'h0001, 1'b0, 1'b0);
            else if (c == P) drive(1'b1, 14'h3FFE, 1'b0, 1'b0);
            else             drive(1'b0, 14'($urandom), 1'b0, 1'b0);
            #1;
            vectors++;
            if (bus.data_ready !== ((c % P) == 0)) begin
                miscompares++;
                $display("FAIL b2b_ready cycle=%0d got %b want %b", c, bus.data_ready, ((c % P) == 0));
            end
            @(posedge clk); #1;
            cap = {cap[25:0], bus.dout_r, bus.dout_f};
            vectors++;
            if (obs !== m_exp) begin
                miscompares++;
                $display("FAIL b2b_out cycle=%0d got %b want %b", c, obs, m_exp);
            end
        end
        vectors++;
        if (cap !== {14'h0001, 14'h3FFE}) begin
            miscompares++;
            $display("FAIL b2b_stream got %h want %h", cap, {14'h0001, 14'h3FFE});
        end
    endtask

    task automatic test_train();
        logic [13:0] d0 = 14'($urandom);
        logic [13:0] cap0 = '0, cap1 = '0;
        logic        tr = 1'b0;
        for (int c = 0; c < 3 * P; c++) begin
            if (c == 3)  tr = 1'b1;
            if (c == 10) tr = 1'b0;
            drive(1'b1, (c == 0) ? d0 : 14'($urandom), tr, 1'b0);
            #1;
            vectors++;
            if (bus.data_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL train_ready cycle=%0d got %b want %b", c, bus.data_ready, exp_ready());
            end
            @(posedge clk); #1;
            if (c < P)          cap0 = {cap0[11:0], bus.dout_r, bus.dout_f};
            else if (c < 2 * P) cap1 = {cap1[11:0], bus.dout_r, bus.dout_f};
            vectors++;
            if (obs !== m_exp) begin
                miscompares++;
                $display("FAIL train_out cycle=%0d got %b want %b", c, obs, m_exp);
            end
        end
        vectors++;
        if (cap0 !== d0) begin
            miscompares++;
            $display("FAIL train_prev_word got %h want %h", cap0, d0);
        end
        vectors++;
        if (cap1 !== 14'h3F80) begin
            miscompares++;
            $display("FAIL train_word got %h want 3f80", cap1);
        end
    endtask

    task automatic test_slip();
        logic [13:0] cap;
        logic        sl;
        for (int w = 0; w < 16; w++) begin
            cap = '0;
            for (int c = 0; c < P; c++) begin
                sl = ((w < 3) && (c == 2)) || ((w >= 4) && (w <= 13) && (c == 0)) ||
                     ((w == 14) && ((c == 2) || (c == 4)));
                drive(1'b1, (w == 3 || w == 15) ? 14'h0001 : 14'($urandom), 1'b0, sl);
                #1;
                vectors++;
                if (bus.data_ready !== exp_ready()) begin
                    miscompares++;
                    $display("FAIL slip_ready word=%0d cycle=%0d got %b want %b", w, c, bus.data_ready, exp_ready());
                end
                @(posedge clk); #1;
                cap = {cap[11:0], bus.dout_r, bus.dout_f};
                vectors++;
                if (obs !== m_exp) begin
                    miscompares++;
                    $display("FAIL slip_out word=%0d cycle=%0d got %b want %b", w, c, obs, m_exp);
                end
            end
            if (w == 3) begin
                vectors++;
                if (cap !== 14'h0008) begin
                    miscompares++;
                    $display("FAIL slip_three got %h want 0008", cap);
                end
            end
            if (w == 15) begin
                vectors++;
                if (cap !== 14'h0001) begin
                    miscompares++;
                    $display("FAIL slip_wrap14 got %h want 0001", cap);
                end
            end
        end
        // A slip in the load cycle rotates the word. A reset then follows
        // mid-word, and the next word must go out unrotated.
        cap = '0;
        for (int c = 0; c < 11; c++) begin
            rst_n = (c == 3) ? 1'b0 : 1'b1;
            drive(1'b1, (c == 4) ? 14'h0001 : 14'($urandom), 1'b0, (c == 0));
            #1;
            vectors++;
            if (bus.data_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rst_ready cycle=%0d got %b want %b", c, bus.data_ready, exp_ready());
            end
            @(posedge clk); #1;
            if (c >= 4) cap = {cap[11:0], bus.dout_r, bus.dout_f};
            vectors++;
            if (obs !== m_exp) begin
                miscompares++;
                $display("FAIL rst_out cycle=%0d got %b want %b", c, obs, m_exp);
            end
        end
        vectors++;
        if (cap !== 14'h0001) begin
            miscompares++;
            $display("FAIL rst_unrotated got %h want 0001", cap);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 9) < 8), 14'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0));
            #1;
            vectors++;
            if (bus.data_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_ready cycle=%0d got %b want %b", c, bus.data_ready, exp_ready());
            end
            @(posedge clk); #1;
            vectors++;
            if (obs !== m_exp) begin
                miscompares++;
                $display("FAIL rand_out cycle=%0d got %b want %b", c, obs, m_exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_underrun();
        test_back_to_back();
        test_train();
        test_slip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
